usb_tx_scheduler: RTL and testbench

// - Sequences the usb_tx transmitter and shares it between two requesters.
//   - Handshake engine (RX side): issues ACK/NAK/STALL.
//   - Data engine (AHB side): issues DATA0/DATA1.
// - Arbitrates the two requesters and issues a one-cycle tx_packet command.
// - Supervises tx_transfer_active/tx_error, enforces inter-packet gap, reports done/fail.

---
 rtl/usb_tx_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_usb_tx_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_scheduler.sv
// Arbitrates handshake/data requesters onto usb_tx, supervises start/error, enforces the IPG.
// Optional build macro USB_TXS_AUTO_TOGGLE_EN: internal DATA0/DATA1 toggle replaces data_pid.
`timescale 1ns/1ps
module usb_tx_scheduler #(
  parameter int unsigned START_TIMEOUT = 8,
  parameter int unsigned IPG_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_req,
  input  logic       data_pid,
  input  logic       ack_rcvd,
  input  logic       clear_toggle,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic [3:0] tx_packet,
  output logic       hs_grant,
  output logic       data_grant,
  output logic       tx_done,
  output logic       tx_fail,
  output logic       busy
);

  localparam int unsigned CntMax = (START_TIMEOUT > IPG_CYCLES) ? START_TIMEOUT : IPG_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StGap    = 3'd4;

  localparam logic [3:0] PktNone  = 4'd0;
  localparam logic [3:0] PktData0 = 4'd1;
  localparam logic [3:0] PktData1 = 4'd2;
  localparam logic [3:0] PktAck   = 4'd3;
  localparam logic [3:0] PktNak   = 4'd4;
  localparam logic [3:0] PktStall = 4'd5;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  logic [3:0]      pkt_q, pkt_d;
  logic            hs_grant_q, hs_grant_d;
  logic            data_grant_q, data_grant_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic            busy_q, busy_d;
  logic            data_sel;
  logic [3:0]      hs_pkt;

`ifdef USB_TXS_AUTO_TOGGLE_EN
  logic toggle_q, toggle_d;
  logic unused_data_pid;

  assign unused_data_pid = data_pid;
  assign data_sel        = toggle_q;

  // clear_toggle has priority over ack_rcvd in the same cycle.
  always_comb begin
    toggle_d = toggle_q;
    if (clear_toggle) begin
      toggle_d = 1'b0;
    end else if (ack_rcvd) begin
      toggle_d = ~toggle_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end
`else
  logic unused_toggle_inputs;

  assign unused_toggle_inputs = ack_rcvd ^ clear_toggle;
  assign data_sel             = data_pid;
`endif

  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    case (hs_type)
      2'd0:    hs_pkt = PktAck;
      2'd1:    hs_pkt = PktNak;
      2'd2:    hs_pkt = PktStall;
      default: hs_pkt = PktNone;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    pkt_d        = PktNone;
    hs_grant_d   = 1'b0;
    data_grant_d = 1'b0;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (hs_req) begin
          hs_grant_d = 1'b1;
          if (hs_type == 2'd3) begin
            // Illegal type: consume the request, burn a gap, never drive usb_tx.
            state_d = StGap;
            cnt_d   = '0;
            fail_d  = 1'b1;
          end else begin
            state_d = StIssue;
            pkt_d   = hs_pkt;
          end
        end else if (data_req) begin
          state_d      = StIssue;
          data_grant_d = 1'b1;
          pkt_d        = data_sel ? PktData1 : PktData0;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (tx_transfer_active) begin
          state_d = StActive;
          err_d   = 1'b0;
        end else if (cnt_inc >= CntW'(START_TIMEOUT)) begin
          state_d = StGap;
          cnt_d   = '0;
          fail_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StActive: begin
        if (tx_error) begin
          err_d = 1'b1;
        end
        if (!tx_transfer_active) begin
          state_d = StGap;
          cnt_d   = '0;
          err_d   = 1'b0;
          fail_d  = err_q | tx_error;
          done_d  = ~(err_q | tx_error);
        end
      end
      StGap: begin
        if (cnt_inc >= CntW'(IPG_CYCLES)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      pkt_q        <= PktNone;
      hs_grant_q   <= 1'b0;
      data_grant_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      pkt_q        <= pkt_d;
      hs_grant_q   <= hs_grant_d;
      data_grant_q <= data_grant_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_packet  = pkt_q;
  assign hs_grant   = hs_grant_q;
  assign data_grant = data_grant_q;
  assign tx_done    = done_q;
  assign tx_fail    = fail_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: stimulus pushes expected output events with their
// cycle of appearance; a negedge monitor pops and compares every non-idle output cycle.
`timescale 1ns/1ps
module tb_usb_tx_scheduler;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       hs_req, data_req, data_pid, ack_rcvd, clear_toggle;
  logic [1:0] hs_type;
  logic       tx_transfer_active, tx_error;
  logic [3:0] tx_packet;
  logic       hs_grant, data_grant, tx_done, tx_fail, busy;

  typedef struct packed {
    int         cyc;
    logic [3:0] pkt;
    logic       hsg;
    logic       dg;
    logic       done;
    logic       fail;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  usb_tx_scheduler dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .hs_req             (hs_req),
    .hs_type            (hs_type),
    .data_req           (data_req),
    .data_pid           (data_pid),
    .ack_rcvd           (ack_rcvd),
    .clear_toggle       (clear_toggle),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .tx_packet          (tx_packet),
    .hs_grant           (hs_grant),
    .data_grant         (data_grant),
    .tx_done            (tx_done),
    .tx_fail            (tx_fail),
    .busy               (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int t, input logic [3:0] p, input logic hg, input logic dg,
                      input logic dn, input logic fl);
    ev_t e;
    e.cyc = t; e.pkt = p; e.hsg = hg; e.dg = dg; e.done = dn; e.fail = fl;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after a rising edge; cyc then names the current cycle.
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sd < 0: transfer never starts. err_off > 0: tx_error pulse that many cycles into ACTIVE.
  task automatic flow(input logic is_hs, input logic [1:0] typ, input logic pid,
                      input logic [3:0] exp_pkt, input int sd, input int len, input int err_off);
    int t0;
    int e;
    if (is_hs) begin
      hs_req = 1'b1; hs_type = typ;
    end else begin
      data_req = 1'b1; data_pid = pid;
    end
    t0 = cyc;
    if (is_hs && typ == 2'd3) begin
      e = t0 + 1;
      push(e, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_until(t0 + 1);
      hs_req = 1'b0;
    end else begin
      push(t0 + 1, exp_pkt, is_hs, !is_hs, 1'b0, 1'b0);
      wait_until(t0 + 1);
      if (is_hs) hs_req = 1'b0;
      else data_req = 1'b0;
      if (sd < 0) begin
        // WAIT_START entered at t0+2; timeout fail visible 8 cycles later.
        e = t0 + 10;
        push(e, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else begin
        e = t0 + 2 + sd + len;
        push(e, 4'd0, 1'b0, 1'b0, err_off == 0, err_off != 0);
        wait_until(t0 + 1 + sd);
        tx_transfer_active = 1'b1;
        if (err_off > 0) begin
          wait_until(t0 + 1 + sd + err_off);
          tx_error = 1'b1;
          wait_until(t0 + 2 + sd + err_off);
          tx_error = 1'b0;
        end
        wait_until(t0 + 1 + sd + len);
        tx_transfer_active = 1'b0;
      end
    end
    wait_until(e + 15);
    chk("busy_in_gap", busy, 1);
    wait_until(e + 16);
    chk("busy_after_gap", busy, 0);
  endtask

  task automatic pulse_toggle(input logic ack, input logic clr);
    ack_rcvd = ack; clear_toggle = clr;
    wait_until(cyc + 1);
    ack_rcvd = 1'b0; clear_toggle = 1'b0;
  endtask

  always @(negedge clk) begin
    ev_t got;
    ev_t exp;
    if (tx_packet != 4'd0 || hs_grant || data_grant || tx_done || tx_fail) begin
      got.cyc = cyc; got.pkt = tx_packet; got.hsg = hs_grant; got.dg = data_grant;
      got.done = tx_done; got.fail = tx_fail;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got cyc=%0d pkt=%0d hsg=%0b dg=%0b done=%0b fail=%0b, required none",
                 got.cyc, got.pkt, got.hsg, got.dg, got.done, got.fail);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d pkt=%0d hsg=%0b dg=%0b done=%0b fail=%0b, required cyc=%0d pkt=%0d hsg=%0b dg=%0b done=%0b fail=%0b",
                   got.cyc, got.pkt, got.hsg, got.dg, got.done, got.fail,
                   exp.cyc, exp.pkt, exp.hsg, exp.dg, exp.done, exp.fail);
        end
      end
    end
  end

  initial begin
    int t0;
    n_rst = 1'b0;
    hs_req = 1'b0; hs_type = 2'd0; data_req = 1'b0; data_pid = 1'b0;
    ack_rcvd = 1'b0; clear_toggle = 1'b0; tx_transfer_active = 1'b0; tx_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {tx_packet, hs_grant, data_grant, tx_done, tx_fail, busy}, 0);
    n_rst = 1'b1;
    wait_until(cyc + 2);
    chk("idle_busy", busy, 0);

    // ACK: start 2 cycles after ISSUE, 20 active cycles, clean finish.
    flow(1'b1, 2'd0, 1'b0, 4'd3, 2, 20, 0);

    // Simultaneous requests: ACK first, DATA1 only after the gap.
    hs_req = 1'b1; hs_type = 2'd0; data_req = 1'b1; data_pid = 1'b1;
    flow(1'b1, 2'd0, 1'b0, 4'd3, 2, 20, 0);
    flow(1'b0, 2'd0, 1'b1, 4'd2, 2, 20, 0);

    // Data request where the transmitter never starts.
    flow(1'b0, 2'd0, 1'b0, 4'd1, -1, 0, 0);

    // NAK with a tx_error pulse mid-transfer.
    flow(1'b1, 2'd1, 1'b0, 4'd4, 1, 10, 5);

    // Illegal handshake type.
    flow(1'b1, 2'd3, 1'b0, 4'd0, 0, 0, 0);

    // STALL started immediately, short transfer.
    flow(1'b1, 2'd2, 1'b0, 4'd5, 0, 3, 0);

`ifdef USB_TXS_AUTO_TOGGLE_EN
    flow(1'b0, 2'd0, 1'b1, 4'd1, 2, 5, 0);
    pulse_toggle(1'b1, 1'b0);
    flow(1'b0, 2'd0, 1'b0, 4'd2, 2, 5, 0);
    pulse_toggle(1'b0, 1'b1);
    flow(1'b0, 2'd0, 1'b1, 4'd1, 2, 5, 0);
    pulse_toggle(1'b1, 1'b1);
    flow(1'b0, 2'd0, 1'b1, 4'd1, 2, 5, 0);
`else
    flow(1'b0, 2'd0, 1'b1, 4'd2, 2, 5, 0);
    pulse_toggle(1'b1, 1'b0);
    flow(1'b0, 2'd0, 1'b0, 4'd1, 2, 5, 0);
    pulse_toggle(1'b0, 1'b1);
    flow(1'b0, 2'd0, 1'b1, 4'd2, 2, 5, 0);
`endif

    // Reset mid-ACTIVE: outputs clear at once, no done/fail for the aborted packet.
    hs_req = 1'b1; hs_type = 2'd1;
    t0 = cyc;
    push(t0 + 1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_until(t0 + 1);
    hs_req = 1'b0;
    wait_until(t0 + 3);
    tx_transfer_active = 1'b1;
    wait_until(t0 + 8);
    n_rst = 1'b0;
    #1;
    chk("reset_abort", {tx_packet, hs_grant, data_grant, tx_done, tx_fail, busy}, 0);
    tx_transfer_active = 1'b0;
    wait_until(t0 + 10);
    n_rst = 1'b1;
    wait_until(t0 + 11);
    chk("after_reset_busy", busy, 0);
    flow(1'b1, 2'd2, 1'b0, 4'd5, 2, 20, 0);

    wait_until(cyc + 5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
